// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_iter_negate_w.sv
// Combinational two's-complement negate (invert and increment), as used by the ALU.
module negate_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/div_iter.sv
// Multicycle signed restoring divider: one quotient bit per clock, fixed latency.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             dz;
  logic             ov;

  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] neg_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  negate_w #(.WIDTH(WIDTH)) u_neg_a (.a(data_operandA), .y(neg_a));
  negate_w #(.WIDTH(WIDTH)) u_neg_b (.a(data_operandB), .y(neg_b));
  negate_w #(.WIDTH(WIDTH)) u_neg_q (.a(dvd),           .y(neg_q));

  // dvd doubles as the quotient: dividend bits leave the top as quotient bits enter the bottom.
  // The shifted remainder is WIDTH+1 bits so the trial subtract keeps its borrow.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      dvd            <= '0;
      dvs            <= '0;
      sign_q         <= 1'b0;
      dz             <= 1'b0;
      ov             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_div) begin
      dvd            <= data_operandA[WIDTH-1] ? neg_a : data_operandA;
      dvs            <= data_operandB[WIDTH-1] ? neg_b : data_operandB;
      sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz             <= (data_operandB == '0);
      ov             <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
      rem            <= '0;
      cnt            <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
      state          <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          data_result    <= dz ? '0 : ov ? INT_MIN : (sign_q ? neg_q : dvd);
          data_exception <= dz | ov;
          data_resultRDY <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed divides, restart and async-reset abort.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  div_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic chk_idle_next = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever RDY is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (chk_idle_next) begin
        chk_idle_next = 1'b0;
        chk("busy_after_rdy", {31'b0, busy}, 32'd0);
        chk("rdy_one_cycle", {31'b0, data_resultRDY}, 32'd0);
      end else if (data_resultRDY === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_rdy", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", data_result, e.res);
          chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
          chk("latency", 32'(cyc - e.start), 32'd33);
          chk_idle_next = 1'b1;
        end
      end
    end
  end

  // Called just after a falling edge; the start is sampled on the next rising edge.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic exc);
    exp_t e;
    if (sb.size() != 0) void'(sb.pop_back());
    e.res = res;
    e.exc = exc;
    e.start = cyc + 1;
    sb.push_back(e);
    ctrl_div      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_div      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout actual=pending required=done");
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc);
    start_div(a, b, res, exc);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_rdy_busy_exc", {29'b0, data_resultRDY, busy, data_exception}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_div(32'd7,          32'd2,          32'h0000_0003, 1'b0);
    run_div(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0);
    run_div(32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 1'b0);
    run_div(32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'h0000_0003, 1'b0);
    run_div(32'h8000_0000,  32'd2,          32'hC000_0000, 1'b0);

    run_div(32'd100,        32'd0,          32'h0000_0000, 1'b1);
    chk("result_held", data_result, 32'd0);
    chk("exc_held", {31'b0, data_exception}, 32'd1);
    start_div(32'd9, 32'd3, 32'h0000_0003, 1'b0);
    chk("exc_cleared_on_start", {31'b0, data_exception}, 32'd0);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_done();

    run_div(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
    run_div(32'd5,          32'd9,          32'h0000_0000, 1'b0);
    run_div(32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 1'b0);
    run_div(32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF, 1'b0);
    run_div(32'h8000_0000,  32'h8000_0000,  32'h0000_0001, 1'b0);
    run_div(32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0000, 1'b0);
    run_div(32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0);

    // Restart mid-run: second start sampled 20 edges after the first.
    start_div(32'd1000, 32'd10, 32'd100, 1'b0);
    repeat (19) @(negedge clock);
    start_div(32'd50, 32'd5, 32'd10, 1'b0);
    wait_done();

    // Asynchronous reset in the middle of a division.
    start_div(32'd1000, 32'd10, 32'd100, 1'b0);
    repeat (15) @(negedge clock);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_rdy_busy_exc", {29'b0, data_resultRDY, busy, data_exception}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("idle_after_reset", {31'b0, busy}, 32'd0);
    run_div(32'd1000, 32'd10, 32'd100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multicycle signed 32-bit integer divider for the processor's multdiv path.
- Uses a restoring shift-subtract datapath.
- Started by a one-cycle ctrl_div pulse from the pipeline's multdiv stall logic; returns the quotient with a one-cycle ready strobe.
- Sits beside the ALU; operand negation uses the same invert-and-increment scheme the ALU uses for subtraction.

Parameters:
- WIDTH, 32, operand/quotient width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ctrl_div  input  1  start pulse; sampled every edge
- data_operandA  input  WIDTH  dividend, two's complement; sampled only on the edge where ctrl_div=1
- data_operandB  input  WIDTH  divisor, two's complement; sampled only on the edge where ctrl_div=1
- data_result  output  WIDTH  quotient, truncated toward zero; registered
- data_exception  output  1  divide-by-zero or overflow flag; registered
- data_resultRDY  output  1  one-cycle strobe; data_result/data_exception valid while high
- busy  output  1  high from the edge after ctrl_div through the RDY cycle

Behaviour:
- Reset is asynchronous and active-high, on one clock.
  - While reset is high: state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0, internal remainder/quotient registers cleared.
  - Reset mid-operation aborts the division immediately; no RDY is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - ctrl_div=1 at edge k latches |A|, |B| (via the negate sub-module when the sign bit is set), sign_q=A[31]^B[31], the dz flag (B==0) and the ov flag (A==0x80000000 && B==0xFFFFFFFF).
  - Same edge: clears remainder and counter, clears data_exception, goes to RUN, raises busy.
- RUN: one restoring step per edge for edges k+1..k+32.
  - rem = {rem[W-2:0], dividend_msb}; trial = rem - |B|.
  - If trial is non-negative: rem=trial, shift in quotient bit 1; else shift in 0.
  - Counter increments; after the 32nd step, go to FIX.
- FIX, edge k+33:
  - data_result = dz ? 0 : ov ? 0x80000000 : (sign_q ? -q : q).
  - data_exception = dz|ov; data_resultRDY <= 1; go to DONE.
- DONE: the cycle following edge k+33 has RDY=1. At edge k+34, RDY <= 0, busy <= 0, state=IDLE.
- Fixed latency: RDY is high exactly during the cycle that begins 33 edges after the sampling edge, independent of operand values, dz or ov.
- Remainder is discarded; the quotient is truncated toward zero (-7/2 = -3).
- The magnitude 0x80000000 is handled by treating |A| as an unsigned 32-bit value. The internal remainder is WIDTH+1 bits so the trial subtract never loses the borrow.
- ctrl_div=1 in RUN/FIX/DONE: aborts the current division and restarts with the newly sampled operands, exactly as from IDLE. RDY for the aborted operation is suppressed, including when the restart edge coincides with the DONE cycle.
- data_result and data_exception hold their last values after DONE until the next FIX or reset.
- Operand inputs are ignored except on the edge where ctrl_div=1.

Decomposition:
- Package div_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3).
  - WIDTH default.
  - constants INT_MIN=32'h8000_0000, NEG_ONE=32'hFFFF_FFFF.
- One sub-module: negate_w, combinational WIDTH-bit two's-complement negate (bitwise invert + increment).
  - Instanced twice for operand magnitudes.
  - Instanced once for result sign correction.
- Counter, FSM and datapath stay in div_iter.

Test Plan:
- Reset, then ctrl_div with A=7, B=2 -> RDY high exactly 33 edges later, data_result=0x00000003, exception=0, busy low the following cycle.
- A=-7 (0xFFFFFFF9), B=2 -> result 0xFFFFFFFD. A=7, B=-2 -> 0xFFFFFFFD. A=-7, B=-2 -> 0x00000003. A=0x80000000, B=2 -> 0xC0000000.
- A=100, B=0 -> RDY at +33, result=0, exception=1; a following divide A=9, B=3 -> exception cleared on the start edge, result=3.
- A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception=1. A=5, B=9 -> result 0, exception=0.
- Start A=1000, B=10; at edge +20 pulse ctrl_div with A=50, B=5 -> no RDY at +33 of the first start; RDY at +33 of the second edge with result=10.
- Start A=1000, B=10; assert reset asynchronously mid-cycle at +15 for 2 cycles -> outputs zero immediately, RDY never asserts, next divide completes normally.
